// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding and default timing constants.
package uart_pkg;
  localparam int unsigned UART_DATA_BITS   = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 10417;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;
endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, start/data/stop FSM and mid-bit sampling.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      enable,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      byte_valid,
  output logic                      frame_err,
  output logic                      bit_start,
  output logic                      idle_c
);
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  rx_state_e                 state_q, state_d;
  logic [CW-1:0]             clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shreg_d;
  logic                      byte_valid_d, frame_err_d, bit_start_d;
  logic [1:0]                sync_q;
  logic                      rx_prev_q;
  logic                      rx_s;

  assign rx_s   = sync_q[1];
  assign idle_c = (state_q == IDLE);

  // Synchroniser and edge history reset to the idle line level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      bit_start  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_byte    <= shreg_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
      bit_start  <= bit_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + CW'(1);
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = rx_byte;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    bit_start_d  = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (enable && rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == CW'(HALF - 1)) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          if (!rx_s) begin
            state_d     = DATA;
            bit_start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_s, rx_byte[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == 3'd7) state_d = STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rx_s) byte_valid_d = 1'b1;
          else      frame_err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides every state and drops any in-flight result
    if (!enable) begin
      state_d      = IDLE;
      clk_cnt_d    = '0;
      bit_cnt_d    = '0;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      bit_start_d  = 1'b0;
    end
  end
endmodule

// File: rtl/uart_rx_128.sv
// 128-bit UART word receiver: assembles NBYTES 8N1 bytes (first byte on top) into data.
// Optional partial-word timeout with a timeout pulse port when UART_RX_TIMEOUT_EN is defined.
module uart_rx_128
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned NBYTES       = 16,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rx,
  input  logic                               enable,
  output logic [UART_DATA_BITS*NBYTES-1:0]   data,
  output logic                               done,
  output logic                               frame_err,
  output logic [4:0]                         byte_cnt
`ifdef UART_RX_TIMEOUT_EN
  ,
  output logic                               timeout
`endif
);
  localparam int unsigned WORD_W = UART_DATA_BITS * NBYTES;

  if (CLKS_PER_BIT < 4 || TIMEOUT_BITS == 0) begin : g_param_check
    $error("uart_rx_128: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS > 0");
  end

  logic [UART_DATA_BITS-1:0] rx_byte;
  logic                      byte_valid, bit_start, idle_c;
  logic [WORD_W-1:0]         word_q, word_next_c;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .enable     (enable),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .bit_start  (bit_start),
    .idle_c     (idle_c)
  );

  assign word_next_c = {word_q[WORD_W-UART_DATA_BITS-1:0], rx_byte};

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_run_c, to_fire_c;

  // Only an idle line with a partial word ages toward the timeout
  assign to_run_c  = idle_c && enable && (byte_cnt != 5'd0) && (byte_cnt < 5'(NBYTES));
  assign to_fire_c = to_run_c && (to_cnt == TO_W'(TO_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_fire_c;
      if (!to_run_c || to_fire_c) to_cnt <= '0;
      else                        to_cnt <= to_cnt + TO_W'(1);
    end
  end
`endif

  // Word assembly, byte counting and the done level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      data     <= '0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else if (!enable) begin
      word_q   <= '0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      if (bit_start) done <= 1'b0;
      if (frame_err) begin
        word_q   <= '0;
        byte_cnt <= '0;
      end else if (byte_valid) begin
        if (byte_cnt == 5'(NBYTES - 1)) begin
          word_q   <= '0;
          data     <= word_next_c;
          done     <= 1'b1;
          byte_cnt <= '0;
        end else begin
          word_q   <= word_next_c;
          byte_cnt <= byte_cnt + 5'd1;
        end
      end
`ifdef UART_RX_TIMEOUT_EN
      else if (to_fire_c) begin
        word_q   <= '0;
        byte_cnt <= '0;
      end
`endif
    end
  end
endmodule
